// File: rtl/led_fade_pkg.sv
// Shared definitions for the LED fade driver: FSM state encoding and
// the helper that maps a logical "lit" value onto the pin polarity.
package led_fade_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } state_t;

  // Pin level for a logical lit/dark value; active-low boards invert.
  function automatic logic led_drive(input logic lit, input logic active_low);
    return lit ^ active_low;
  endfunction

endpackage

// File: rtl/led_fade_pwm_gen.sv
// Free-running PWM counter and duty compare. Duty at full scale is
// forced to 100% on so the LED never flickers dark at the counter wrap.
module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_on
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [PWM_BITS-1:0] r_pwm_cnt;

  // Counter runs 0..MAX and wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) r_pwm_cnt <= '0;
    else       r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end

  assign pwm_on = (duty == MAX) || (r_pwm_cnt < duty);

endmodule

// File: rtl/led_fade.sv
// PWM LED driver whose brightness ramps between dark and full scale
// following a synchronous on/off request, one duty step per prescaler tick.
module led_fade
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS       = 8,
  parameter int STEP_CNT       = 4,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic                led,
  output logic [PWM_BITS-1:0] level,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] MAX    = '1;
  localparam int                  STEP_W = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CNT - 1);
  localparam logic                AL     = (LED_ACTIVE_LOW != 0);

  state_t              r_state;
  logic [PWM_BITS-1:0] r_duty;
  logic [STEP_W-1:0]   r_step_cnt;
  logic                r_led;
  logic                w_tick;
  logic                w_pwm_on;

  assign w_tick = (r_step_cnt == STEP_LAST);

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk    (clk),
    .reset  (reset),
    .duty   (r_duty),
    .pwm_on (w_pwm_on)
  );

  // Ramp FSM with prescaler and duty register; reversal beats a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_OFF;
      r_duty     <= '0;
      r_step_cnt <= '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          r_duty     <= '0;
          r_step_cnt <= '0;
          if (en) r_state <= ST_RISE;
        end
        ST_RISE: begin
          if (!en) begin
            r_state    <= ST_FALL;
            r_step_cnt <= '0;
          end else if (r_duty == MAX) begin
            // Entered RISE at full scale after a quick reversal from ON.
            r_state    <= ST_ON;
            r_step_cnt <= '0;
          end else if (w_tick) begin
            r_step_cnt <= '0;
            r_duty     <= r_duty + 1'b1;
            if (r_duty == MAX - 1'b1) r_state <= ST_ON;
          end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
          end
        end
        ST_ON: begin
          r_duty     <= MAX;
          r_step_cnt <= '0;
          if (!en) r_state <= ST_FALL;
        end
        ST_FALL: begin
          if (en) begin
            r_state    <= ST_RISE;
            r_step_cnt <= '0;
          end else if (r_duty == '0) begin
            // Already dark (short pulse from OFF): nothing left to ramp.
            r_state    <= ST_OFF;
            r_step_cnt <= '0;
          end else if (w_tick) begin
            r_step_cnt <= '0;
            r_duty     <= r_duty - 1'b1;
            if (r_duty == {{(PWM_BITS-1){1'b0}}, 1'b1}) r_state <= ST_OFF;
          end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= ST_OFF;
          r_duty     <= '0;
          r_step_cnt <= '0;
        end
      endcase
    end
  end

  // Registered pin drive so the LED output is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) r_led <= led_drive(1'b0, AL);
    else       r_led <= led_drive(w_pwm_on, AL);
  end

  assign led   = r_led;
  assign level = r_duty;
  assign busy  = (r_state == ST_RISE) || (r_state == ST_FALL);

endmodule

// File: tb/tb_led_fade.sv
// Directed bench for led_fade: reset, full ramp, reversals, reset
// mid-ramp, PWM duty measurement and short enable pulses.
module tb_led_fade;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, en_a = 1'b0;
  logic       rst_b = 1'b1, en_b = 1'b0;
  logic       rst_c = 1'b1, en_c = 1'b0;
  logic       led_a, led_b, led_c;
  logic [3:0] lvl_a, lvl_b, lvl_c;
  logic       busy_a, busy_b, busy_c;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_fade #(.PWM_BITS(4), .STEP_CNT(2), .LED_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .reset(rst_a), .en(en_a), .led(led_a), .level(lvl_a), .busy(busy_a));

  led_fade #(.PWM_BITS(4), .STEP_CNT(64), .LED_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .reset(rst_b), .en(en_b), .led(led_b), .level(lvl_b), .busy(busy_b));

  led_fade #(.PWM_BITS(4), .STEP_CNT(2), .LED_ACTIVE_LOW(0)) dut_c (
    .clk(clk), .reset(rst_c), .en(en_c), .led(led_c), .level(lvl_c), .busy(busy_c));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt;
    int waited;

    // Test 1: reset held with en=1
    rst_a = 1'b1; en_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t1_rst_led", 32'(led_a), 1);
      chk("t1_rst_level", 32'(lvl_a), 0);
      chk("t1_rst_busy", 32'(busy_a), 0);
    end
    rst_a = 1'b0;
    step(1);
    chk("t1_busy_after_release", 32'(busy_a), 1);
    rst_a = 1'b1; en_a = 1'b0;
    step(1);
    rst_a = 1'b0;
    step(2);
    chk("t1_idle_busy", 32'(busy_a), 0);

    // Test 2: full ramp up from OFF
    en_a = 1'b1;
    step(1);
    chk("t2_k1_busy", 32'(busy_a), 1);
    chk("t2_k1_level", 32'(lvl_a), 0);
    step(1);
    chk("t2_k2_level", 32'(lvl_a), 0);
    step(1);
    chk("t2_k3_level", 32'(lvl_a), 1);
    step(27);
    chk("t2_k30_level", 32'(lvl_a), 14);
    chk("t2_k30_busy", 32'(busy_a), 1);
    step(1);
    chk("t2_k31_level", 32'(lvl_a), 15);
    chk("t2_k31_busy", 32'(busy_a), 0);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step(1);
      if (led_a !== 1'b0) cnt++;
    end
    chk("t2_on_led_not_lit", 32'(cnt), 0);

    // ON -> FALL -> RISE reversal, finishing on the MAX-1 tick
    en_a = 1'b0;
    step(1);
    chk("t2r_fall_busy", 32'(busy_a), 1);
    chk("t2r_fall_level0", 32'(lvl_a), 15);
    step(1);
    chk("t2r_fall_level1", 32'(lvl_a), 15);
    step(1);
    chk("t2r_fall_level2", 32'(lvl_a), 14);
    en_a = 1'b1;
    step(1);
    chk("t2r_rise_level0", 32'(lvl_a), 14);
    chk("t2r_rise_busy", 32'(busy_a), 1);
    step(1);
    chk("t2r_rise_level1", 32'(lvl_a), 14);
    step(1);
    chk("t2r_on_level", 32'(lvl_a), 15);
    chk("t2r_on_busy", 32'(busy_a), 0);

    // Test 3: reversal from RISE at level 7, ramp down to OFF
    rst_a = 1'b1; en_a = 1'b0;
    step(1);
    rst_a = 1'b0;
    en_a = 1'b1;
    step(15);
    chk("t3_rise_level7", 32'(lvl_a), 7);
    en_a = 1'b0;
    step(1);
    chk("t3_rev_busy", 32'(busy_a), 1);
    chk("t3_rev_level0", 32'(lvl_a), 7);
    step(1);
    chk("t3_rev_level1", 32'(lvl_a), 7);
    step(1);
    chk("t3_rev_level2", 32'(lvl_a), 6);
    step(11);
    chk("t3_level1", 32'(lvl_a), 1);
    chk("t3_busy_before_off", 32'(busy_a), 1);
    step(1);
    chk("t3_off_level", 32'(lvl_a), 0);
    chk("t3_off_busy", 32'(busy_a), 0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (led_a !== 1'b1) cnt++;
    end
    chk("t3_off_led_dark", 32'(cnt), 0);

    // Test 4: reset mid-RISE at level 5
    en_a = 1'b1;
    step(11);
    chk("t4_rise_level5", 32'(lvl_a), 5);
    rst_a = 1'b1;
    step(1);
    chk("t4_rst_level", 32'(lvl_a), 0);
    chk("t4_rst_busy", 32'(busy_a), 0);
    chk("t4_rst_led", 32'(led_a), 1);
    rst_a = 1'b0; en_a = 1'b0;
    step(3);
    chk("t4_stay_off_busy", 32'(busy_a), 0);
    chk("t4_stay_off_level", 32'(lvl_a), 0);
    chk("t4_stay_off_led", 32'(led_a), 1);

    // Test 6: one-cycle enable pulse from OFF
    en_a = 1'b1;
    step(1);
    chk("t6_rise_busy", 32'(busy_a), 1);
    chk("t6_rise_level", 32'(lvl_a), 0);
    en_a = 1'b0;
    step(1);
    chk("t6_fall_busy", 32'(busy_a), 1);
    chk("t6_fall_level", 32'(lvl_a), 0);
    step(1);
    chk("t6_off_busy", 32'(busy_a), 0);
    chk("t6_off_level", 32'(lvl_a), 0);

    // Test 6 active-high variant
    step(1);
    chk("t6h_rst_led", 32'(led_c), 0);
    rst_c = 1'b0;
    step(2);
    chk("t6h_idle_led", 32'(led_c), 0);
    en_c = 1'b1;
    step(1);
    chk("t6h_rise_busy", 32'(busy_c), 1);
    en_c = 1'b0;
    step(1);
    chk("t6h_fall_busy", 32'(busy_c), 1);
    step(1);
    chk("t6h_off_busy", 32'(busy_c), 0);
    chk("t6h_off_level", 32'(lvl_c), 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (led_c !== 1'b0) cnt++;
    end
    chk("t6h_led_idle", 32'(cnt), 0);

    // Test 5: PWM duty measurement with slow prescaler
    rst_b = 1'b0;
    step(2);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (led_b === 1'b0) cnt++;
    end
    chk("t5_lit_at_level0", 32'(cnt), 0);
    en_b = 1'b1;
    step(1);
    chk("t5_busy", 32'(busy_b), 1);
    step(191);
    chk("t5_k192_level", 32'(lvl_b), 2);
    step(1);
    chk("t5_k193_level", 32'(lvl_b), 3);
    step(1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (led_b === 1'b0) cnt++;
    end
    chk("t5_lit_at_level3", 32'(cnt), 3);
    waited = 0;
    while (busy_b === 1'b1 && waited < 2000) begin
      step(1);
      waited++;
    end
    chk("t5_on_reached", 32'(busy_b), 0);
    chk("t5_on_level", 32'(lvl_b), 15);
    step(2);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (led_b === 1'b0) cnt++;
    end
    chk("t5_lit_in_on", 32'(cnt), 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
